jtframe_rom_sched: RTL and testbench
====================================

Name: jtframe_rom_sched

Overview:
- Round-robin SDRAM read scheduler shared by SLOTS ROM requesters (GFX1, GFX2, ADPCM, sound, main) of the game top level.
- Each slot owns a one-entry 32-bit cache, tagged by its word address.
- A slot sees ok/dout on a hit. Misses are queued and serviced one at a time over the single sdram_req/ack/data_rdy channel.
- Sits between the CPU/video/sound ROM ports and the SDRAM controller. Slot addresses arrive already offset-added.

Parameters:
- SLOTS, 4, number of requesters (2..8).
- AW, 22, SDRAM word-address width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- downloading  in  1  ROM download in progress; scheduler held idle.
- slot_cs  in  SLOTS  per-slot read request (level).
- slot_addr  in  SLOTS*AW  per-slot 16-bit word address; slot i at bits [i*AW +: AW].
- slot_ok  out  SLOTS  slot i cache holds its current address.
- slot_dout  out  SLOTS*32  per-slot cached 32-bit line; slot i at bits [i*32 +: 32].
- sdram_req  out  1  read request to the SDRAM controller.
- sdram_addr  out  AW  word address of the request; LSB always 0.
- sdram_ack  in  1  controller accepted the request (1-cycle pulse).
- data_rdy  in  1  data_read valid (1-cycle pulse).
- data_read  in  32  returned line.
- refresh_en  out  1  controller may refresh now.

Behaviour:
- Reset values: sdram_req=0, sdram_addr=0, slot_ok=0, slot_dout=0, refresh_en=1. All valid bits=0. State=IDLE. rr_ptr=0.
- Tag and hit:
  - tag_i = slot_addr_i[AW-1:1].
  - hit_i = valid_i & (tag_reg_i == tag_i).
  - slot_ok_i = slot_cs_i & hit_i, combinational from registers and inputs.
  - The word in dout is selected by the slot, not by this block.
- Miss: miss_i = slot_cs_i & ~hit_i & ~(busy & cur==i).
- State IDLE:
  - If ~downloading and any miss: pick the first miss scanning rr_ptr, rr_ptr+1, … modulo SLOTS.
  - Latch cur=i and lat_tag=tag_i. Set sdram_addr={tag_i,1'b0} and sdram_req=1. Go to WAIT_ACK.
  - rr_ptr <= i+1, wrapping to 0 at SLOTS.
  - Request issues the cycle after the miss is seen (1-cycle latency).
- State WAIT_ACK:
  - Hold sdram_req=1 and sdram_addr stable until sdram_ack.
  - On ack: sdram_req=0, go to WAIT_DATA.
  - If ack and data_rdy arrive in the same cycle, complete immediately as in WAIT_DATA.
- State WAIT_DATA:
  - On data_rdy: dout_cur<=data_read, tag_reg_cur<=lat_tag, valid_cur<=1. Go to IDLE.
  - Next arbitration happens in the following cycle.
- data_rdy outside WAIT_ACK/WAIT_DATA is ignored.
- Address change mid-request: the fill still stores lat_tag. The slot then misses on its new tag and is re-queued. No abort.
- A slot dropping cs mid-request is still filled.
- refresh_en=1 only in IDLE with no miss pending. Otherwise 0.
- downloading=1, any state:
  - Next cycle: state=IDLE, sdram_req=0, all valid=0.
  - Outstanding data_rdy is dropped.
  - slot_ok=0 while downloading.
- Reset mid-operation gives the same result as power-up reset. A pending ack/data_rdy after reset is ignored.
- Hit-latency worst case with all slots missing: SLOTS × (controller round-trip + 1) cycles.

Decomposition:
- Shared package jtframe_rom_pkg:
  - state encoding {IDLE, WAIT_ACK, WAIT_DATA}.
  - localparam LINE_W=32.
  - function for round-robin first-one search.
- Sub-module jtframe_rom_slotcache, instantiated SLOTS times:
  - holds valid, tag, dout; computes hit/ok.
  - fill strobe and clear input.

Test Plan:
- Single miss: slot0 cs=1, addr=22'h00_1235.
  - Next cycle sdram_req=1, sdram_addr=22'h00_1234.
  - Ack after 3 cycles, data_rdy with 32'hDEAD_BEEF 4 cycles later.
  - Then slot_ok[0]=1 and dout0=32'hDEAD_BEEF. addr 22'h00_1234 is also a hit with no new req.
- Round-robin: all four slots miss simultaneously at reset.
  - Service order 0,1,2,3.
  - Then slot1 and slot3 miss again: order 1? No — rr_ptr=0 wraps, so order 1 then 3. Slot0 refilled first if it misses too.
- Address change mid-request: slot2 addr changes from 22'h10 to 22'h40 between ack and data_rdy.
  - slot_ok[2] stays 0.
  - Second request to 22'h40 is issued after the fill.
- Same-cycle ack+data_rdy: in WAIT_ACK, data stored, state returns to IDLE, no hang.
- downloading asserted in WAIT_DATA: sdram_req=0 and all slot_ok=0.
  - Late data_rdy ignored.
  - After downloading drops, previously cached addresses re-request.
- Reset: rst pulsed while sdram_req=1.
  - Next cycle sdram_req=0, refresh_en=1, all slot_ok=0.

Source files
------------

// File: rtl/jtframe_rom_pkg.sv
// rtl/jtframe_rom_pkg.sv - shared types and helpers for the ROM read scheduler
package jtframe_rom_pkg;

  localparam int LINE_W    = 32;
  localparam int MAX_SLOTS = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DATA = 2'd2
  } state_e;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit of req visited in the order ptr, ptr+1, ... modulo n.
  // Scanning from the far end lets the nearest candidate overwrite the rest.
  function automatic rr_pick_t rr_first(input logic [MAX_SLOTS-1:0] req,
                                        input logic [2:0]           ptr,
                                        input int                   n);
    rr_pick_t pick;
    int       j;
    pick = '0;
    for (int k = MAX_SLOTS-1; k >= 0; k--) begin
      if (k < n) begin
        j = (int'(ptr) + k) % n;
        if (req[3'(j)]) begin
          pick.found = 1'b1;
          pick.idx   = 3'(j);
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/jtframe_rom_slotcache.sv
// rtl/jtframe_rom_slotcache.sv - one-entry tagged line cache owned by a single ROM slot
module jtframe_rom_slotcache
  import jtframe_rom_pkg::*;
#(
  parameter int AW = 22
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              fill_i,
  input  logic [AW-2:0]     fill_tag_i,
  input  logic [LINE_W-1:0] fill_data_i,
  input  logic              cs_i,
  input  logic [AW-2:0]     tag_i,
  output logic              hit_o,
  output logic              ok_o,
  output logic [LINE_W-1:0] dout_o
);

  logic              valid_q;
  logic [AW-2:0]     tag_q;
  logic [LINE_W-1:0] dout_q;

  // Line storage: clear wins over a fill so a download always empties the cache.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      dout_q  <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (fill_i) begin
      valid_q <= 1'b1;
      tag_q   <= fill_tag_i;
      dout_q  <= fill_data_i;
    end
  end

  // clear_i also masks ok in the cycle before valid_q actually drops.
  assign hit_o  = valid_q & (tag_q == tag_i);
  assign ok_o   = cs_i & hit_o & ~clear_i;
  assign dout_o = dout_q;

endmodule

// File: rtl/jtframe_rom_sched.sv
// rtl/jtframe_rom_sched.sv - round-robin SDRAM read scheduler for per-slot ROM line caches
module jtframe_rom_sched
  import jtframe_rom_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int AW    = 22
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    downloading_i,
  input  logic [SLOTS-1:0]        slot_cs_i,
  input  logic [SLOTS*AW-1:0]     slot_addr_i,
  output logic [SLOTS-1:0]        slot_ok_o,
  output logic [SLOTS*LINE_W-1:0] slot_dout_o,
  output logic                    sdram_req_o,
  output logic [AW-1:0]           sdram_addr_o,
  input  logic                    sdram_ack_i,
  input  logic                    data_rdy_i,
  input  logic [LINE_W-1:0]       data_read_i,
  output logic                    refresh_en_o
);

  localparam int IW = $clog2(SLOTS);

  typedef logic [AW-2:0] tag_t;

  tag_t             tag [SLOTS];
  logic [SLOTS-1:0] hit;
  logic [SLOTS-1:0] miss;
  logic [SLOTS-1:0] fill;
  logic [SLOTS-1:0] unused_lsb;
  logic             busy;
  logic             fill_en;

  state_e           state_q, state_d;
  logic [IW-1:0]    cur_q, cur_d;
  logic [IW-1:0]    rr_q, rr_d;
  tag_t             lat_tag_q, lat_tag_d;
  logic             req_q, req_d;
  logic [AW-1:0]    addr_q, addr_d;

  rr_pick_t         pick;
  rr_pick_t         unused_pick;
  logic [IW-1:0]    pick_idx;

  assign busy = (state_q != IDLE);

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    // A line covers two 16-bit words, so the word LSB is not part of the tag.
    assign tag[i]        = slot_addr_i[i*AW+1 +: AW-1];
    assign unused_lsb[i] = slot_addr_i[i*AW];
    assign fill[i]       = fill_en & (cur_q == IW'(i));
    // The slot being serviced is not a miss again until its fill lands.
    assign miss[i]       = slot_cs_i[i] & ~hit[i] & ~(busy & (cur_q == IW'(i)));

    jtframe_rom_slotcache #(.AW(AW)) u_cache (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clear_i     (downloading_i),
      .fill_i      (fill[i]),
      .fill_tag_i  (lat_tag_q),
      .fill_data_i (data_read_i),
      .cs_i        (slot_cs_i[i]),
      .tag_i       (tag[i]),
      .hit_o       (hit[i]),
      .ok_o        (slot_ok_o[i]),
      .dout_o      (slot_dout_o[i*LINE_W +: LINE_W])
    );
  end

  assign pick        = rr_first(MAX_SLOTS'(miss), 3'(rr_q), SLOTS);
  assign pick_idx    = pick.idx[IW-1:0];
  assign unused_pick = pick;

  // Scheduler state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cur_q     <= '0;
      rr_q      <= '0;
      lat_tag_q <= '0;
      req_q     <= 1'b0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      rr_q      <= rr_d;
      lat_tag_q <= lat_tag_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
    end
  end

  // Arbitration, request handshake and fill strobe.
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    rr_d      = rr_q;
    lat_tag_d = lat_tag_q;
    req_d     = req_q;
    addr_d    = addr_q;
    fill_en   = 1'b0;
    if (downloading_i) begin
      state_d = IDLE;
      req_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick.found) begin
            cur_d     = pick_idx;
            lat_tag_d = tag[pick_idx];
            addr_d    = {tag[pick_idx], 1'b0};
            req_d     = 1'b1;
            rr_d      = (pick_idx == IW'(SLOTS-1)) ? '0 : pick_idx + IW'(1);
            state_d   = WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (sdram_ack_i) begin
            req_d = 1'b0;
            if (data_rdy_i) begin
              fill_en = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = WAIT_DATA;
            end
          end
        end
        WAIT_DATA: begin
          if (data_rdy_i) begin
            fill_en = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign sdram_req_o  = req_q;
  assign sdram_addr_o = addr_q;
  assign refresh_en_o = (state_q == IDLE) & ~|miss;

endmodule

// File: tb/tb_jtframe_rom_sched.sv
// tb/tb_jtframe_rom_sched.sv - self-checking bench for the ROM read scheduler
`timescale 1ns/1ps
module tb_jtframe_rom_sched;

  localparam int SLOTS = 4;
  localparam int AW    = 22;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 downloading;
  logic [SLOTS-1:0]     cs;
  logic [SLOTS*AW-1:0]  addr;
  logic [SLOTS-1:0]     ok;
  logic [SLOTS*32-1:0]  dout;
  logic                 req;
  logic [AW-1:0]        sdram_addr;
  logic                 ack;
  logic                 data_rdy;
  logic [31:0]          data_read;
  logic                 refresh_en;

  int checks = 0;
  int errors = 0;

  jtframe_rom_sched #(.SLOTS(SLOTS), .AW(AW)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .downloading_i (downloading),
    .slot_cs_i     (cs),
    .slot_addr_i   (addr),
    .slot_ok_o     (ok),
    .slot_dout_o   (dout),
    .sdram_req_o   (req),
    .sdram_addr_o  (sdram_addr),
    .sdram_ack_i   (ack),
    .data_rdy_i    (data_rdy),
    .data_read_i   (data_read),
    .refresh_en_o  (refresh_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cs0;
    logic [21:0] addr0;
    logic        exp_ok;
    logic        exp_refresh;
  } vec_t;

  vec_t vecs [7];

  // Reference model: per-slot cache contents and round-robin start point.
  logic        m_valid [SLOTS];
  logic [20:0] m_tag   [SLOTS];
  logic [31:0] m_data  [SLOTS];
  logic        mm      [SLOTS];
  int          m_rr;
  int          g;
  logic [31:0] rd;
  logic [20:0] t_tag;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    addr[i*AW +: AW] = a;
  endtask

  function automatic logic [31:0] dout_of(input int i);
    return dout[i*32 +: 32];
  endfunction

  task automatic do_reset();
    rst = 1'b1; cs = '0; ack = 1'b0; data_rdy = 1'b0; downloading = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Expect a request to issue on the next edge, then ack after ack_dly wait
  // cycles and data dat_dly cycles after the ack (0 = same cycle as ack).
  task automatic serve(input logic [AW-1:0] exp_addr, input int ack_dly,
                       input int dat_dly, input logic [31:0] d);
    tick();
    chk("issue_req", req, 1'b1);
    chk("issue_addr", sdram_addr, exp_addr);
    chk("busy_refresh", refresh_en, 1'b0);
    repeat (ack_dly) begin
      tick();
      chk("hold_req", req, 1'b1);
      chk("hold_addr", sdram_addr, exp_addr);
    end
    ack = 1'b1;
    if (dat_dly == 0) begin
      data_rdy = 1'b1; data_read = d;
    end
    tick();
    ack = 1'b0; data_rdy = 1'b0;
    if (dat_dly > 0) begin
      chk("req_drop", req, 1'b0);
      repeat (dat_dly - 1) tick();
      data_rdy = 1'b1; data_read = d;
      tick();
      data_rdy = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; downloading = 1'b0; cs = '0; addr = '0;
    ack = 1'b0; data_rdy = 1'b0; data_read = '0;

    vecs[0] = '{1'b1, 22'h00_1234, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 22'h00_1235, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 22'h00_1234, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 22'h00_1236, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 22'h00_1233, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 22'h20_1234, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 22'h00_1236, 1'b0, 1'b1};

    // Reset state
    do_reset();
    chk("rst_req", req, 1'b0);
    chk("rst_addr", sdram_addr, '0);
    chk("rst_ok", ok, '0);
    chk("rst_dout", dout, '0);
    chk("rst_refresh", refresh_en, 1'b1);

    // Single miss
    cs = 4'b0001; set_addr(0, 22'h00_1235);
    #1;
    chk("miss_ok", ok[0], 1'b0);
    chk("miss_refresh", refresh_en, 1'b0);
    serve(22'h00_1234, 2, 4, 32'hDEAD_BEEF);
    chk("single_ok", ok[0], 1'b1);
    chk("single_dout", dout_of(0), 32'hDEAD_BEEF);
    set_addr(0, 22'h00_1234);
    tick();
    chk("hit_noreq", req, 1'b0);
    chk("hit_ok", ok[0], 1'b1);

    // Combinational hit/ok/refresh table against the cached line
    for (int v = 0; v < 7; v++) begin
      cs[0] = vecs[v].cs0; set_addr(0, vecs[v].addr0);
      #1;
      chk($sformatf("vec%0d_ok", v), ok[0], vecs[v].exp_ok);
      chk($sformatf("vec%0d_refresh", v), refresh_en, vecs[v].exp_refresh);
    end

    // Round-robin from reset: all four miss together
    do_reset();
    cs = 4'hF;
    for (int i = 0; i < SLOTS; i++) set_addr(i, 22'(32'h100 * (i + 1)));
    for (int i = 0; i < SLOTS; i++) serve(22'(32'h100 * (i + 1)), 1, 1, 32'hA000_0000 + i);
    chk("rr_all_ok", ok, 4'hF);
    for (int i = 0; i < SLOTS; i++) chk("rr_dout", dout_of(i), 32'hA000_0000 + i);
    set_addr(1, 22'h204); set_addr(3, 22'h404);
    serve(22'h204, 0, 2, 32'hB1B1_B1B1);
    serve(22'h404, 1, 0, 32'hB3B3_B3B3);
    chk("rr2_ok", ok, 4'hF);
    chk("rr2_dout1", dout_of(1), 32'hB1B1_B1B1);
    chk("rr2_dout3", dout_of(3), 32'hB3B3_B3B3);

    // Address change between ack and data
    do_reset();
    cs = 4'b0100; set_addr(2, 22'h10);
    tick();
    chk("chg_addr", sdram_addr, 22'h10);
    ack = 1'b1; tick(); ack = 1'b0;
    set_addr(2, 22'h40);
    #1;
    chk("chg_ok_mid", ok[2], 1'b0);
    data_rdy = 1'b1; data_read = 32'h1111_1111;
    tick();
    data_rdy = 1'b0;
    chk("chg_ok_after", ok[2], 1'b0);
    chk("chg_dout_old", dout_of(2), 32'h1111_1111);
    serve(22'h40, 0, 1, 32'h4040_4040);
    chk("chg_ok_new", ok[2], 1'b1);
    chk("chg_dout_new", dout_of(2), 32'h4040_4040);

    // Same-cycle ack and data_rdy
    do_reset();
    cs = 4'b0001; set_addr(0, 22'h300);
    serve(22'h300, 0, 0, 32'h5A5A_5A5A);
    chk("same_ok", ok[0], 1'b1);
    chk("same_dout", dout_of(0), 32'h5A5A_5A5A);
    set_addr(0, 22'h302);
    serve(22'h302, 2, 0, 32'hC3C3_C3C3);
    chk("same2_dout", dout_of(0), 32'hC3C3_C3C3);

    // Download starting in WAIT_DATA
    do_reset();
    cs = 4'b0011; set_addr(0, 22'h500); set_addr(1, 22'h600);
    serve(22'h500, 0, 1, 32'h0000_0500);
    tick();
    chk("dl_issue1", sdram_addr, 22'h600);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("dl_ok0_pre", ok[0], 1'b1);
    downloading = 1'b1;
    #1;
    chk("dl_ok_gate", ok, '0);
    tick();
    chk("dl_req", req, 1'b0);
    chk("dl_ok", ok, '0);
    data_rdy = 1'b1; data_read = 32'hBAD0_BAD0;
    tick();
    data_rdy = 1'b0;
    tick();
    downloading = 1'b0;
    #1;
    chk("dl_after_ok", ok, '0);
    chk("dl_after_refresh", refresh_en, 1'b0);
    serve(22'h500, 1, 1, 32'h0000_0501);
    serve(22'h600, 1, 1, 32'h0000_0601);
    chk("dl_refill_ok", ok[1:0], 2'b11);
    chk("dl_refill_dout1", dout_of(1), 32'h0000_0601);

    // Reset while a request is pending
    do_reset();
    cs = 4'b0001; set_addr(0, 22'h700);
    tick();
    chk("mrst_req_pre", req, 1'b1);
    rst = 1'b1; cs = '0;
    tick();
    rst = 1'b0;
    chk("mrst_req", req, 1'b0);
    chk("mrst_refresh", refresh_en, 1'b1);
    chk("mrst_ok", ok, '0);
    ack = 1'b1; data_rdy = 1'b1; data_read = 32'h7777_7777;
    tick();
    ack = 1'b0; data_rdy = 1'b0;
    chk("mrst_late_req", req, 1'b0);
    cs = 4'b0001;
    #1;
    chk("mrst_late_ok", ok[0], 1'b0);
    chk("mrst_late_dout", dout_of(0), 32'h0);

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < SLOTS; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = '0; m_data[i] = '0;
    end
    m_rr = 0;
    for (int t = 0; t < 80; t++) begin
      cs = 4'($urandom);
      for (int i = 0; i < SLOTS; i++) set_addr(i, 22'(i * 16 + $urandom_range(0, 3)));
      #1;
      g = -1;
      for (int i = 0; i < SLOTS; i++) begin
        t_tag = addr[i*AW+1 +: AW-1];
        mm[i] = cs[i] && !(m_valid[i] && m_tag[i] == t_tag);
        chk($sformatf("rnd_ok%0d", i), ok[i], cs[i] && m_valid[i] && m_tag[i] == t_tag);
        if (m_valid[i]) chk($sformatf("rnd_dout%0d", i), dout_of(i), m_data[i]);
      end
      for (int k = 0; k < SLOTS; k++) begin
        if (g < 0 && mm[(m_rr + k) % SLOTS]) g = (m_rr + k) % SLOTS;
      end
      chk("rnd_refresh", refresh_en, g < 0);
      if (g < 0) begin
        tick();
        chk("rnd_noreq", req, 1'b0);
      end else begin
        rd = $urandom;
        t_tag = addr[g*AW+1 +: AW-1];
        serve({t_tag, 1'b0}, $urandom_range(0, 3), $urandom_range(0, 3), rd);
        m_valid[g] = 1'b1; m_tag[g] = t_tag; m_data[g] = rd;
        m_rr = (g + 1) % SLOTS;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
